// File: rtl/uart_bus_master_if.sv
// Command/response handshake plus the 8-bit register bus of the UART peripheral.
// The master modport is the bus initiator's view. The slave modport is the host/peripheral side.
interface uart_bus_master_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_write;
  logic [7:0] cmd_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       rsp_timeout;
  logic [1:0] bus_addr;
  logic       bus_ncs;
  logic       bus_nwe;
  logic       bus_nrst;
  logic [7:0] bus_dout;
  logic       bus_doe;
  logic [7:0] bus_din;

  modport master (
    input  cmd_valid, cmd_write, cmd_wdata, bus_din,
    output cmd_ready, rsp_valid, rsp_data, rsp_timeout,
    output bus_addr, bus_ncs, bus_nwe, bus_nrst, bus_dout, bus_doe
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_wdata, bus_din,
    input  cmd_ready, rsp_valid, rsp_data, rsp_timeout,
    input  bus_addr, bus_ncs, bus_nwe, bus_nrst, bus_dout, bus_doe
  );
endinterface

// File: rtl/uart_bus_master.sv
// Bus initiator for the UART register interface. Each command polls status (addr 0),
// then performs one data-register cycle (addr 1), then returns a single response pulse.
module uart_bus_master #(
  parameter int ACTIVE_CYCLES = 4,
  parameter int IDLE_CYCLES   = 2,
  parameter int POLL_MAX      = 255
) (
  input  logic              clk,
  input  logic              rst,
  uart_bus_master_if.master bus
);

  typedef enum logic [2:0] {S_IDLE, S_POLL, S_CHECK, S_XFER, S_RESP} cmd_state_t;
  typedef enum logic [1:0] {P_SETUP, P_ACTIVE, P_HOLD, P_GAP} bus_phase_t;

  localparam logic [3:0] ACT_LAST     = 4'(ACTIVE_CYCLES - 1);
  localparam logic [3:0] GAP_LAST     = 4'(IDLE_CYCLES - 1);
  localparam logic [7:0] POLL_LAST    = 8'(POLL_MAX - 1);
  localparam logic       POLL_LIMITED = (POLL_MAX != 0);

  cmd_state_t state, state_nx;
  bus_phase_t phase, phase_nx;
  logic [3:0] ph_cnt;
  logic [7:0] poll_cnt;
  logic       is_wr;
  logic       timed_out;
  logic [7:0] wr_byte_p0;
  logic [7:0] rd_byte_p1;

  logic ph_last, in_bus, wr_cyc, status_ok, poll_exhausted, take_cmd, sample_din;

  always_comb begin
    ph_last = 1'b1;
    case (phase)
      P_ACTIVE: ph_last = (ph_cnt == ACT_LAST);
      P_GAP:    ph_last = (ph_cnt == GAP_LAST);
      default:  ph_last = 1'b1;
    endcase
  end

  assign in_bus         = (state == S_POLL) || (state == S_XFER);
  assign wr_cyc         = (state == S_XFER) && is_wr;
  assign status_ok      = is_wr ? ~rd_byte_p1[0] : rd_byte_p1[1];
  assign poll_exhausted = POLL_LIMITED && (poll_cnt == POLL_LAST);
  assign take_cmd       = (state == S_IDLE) && bus.cmd_valid;
  // Data arrives at the edge that ends the last ACTIVE clock. Status polls and data reads share this register.
  assign sample_din     = in_bus && (phase == P_ACTIVE) && ph_last && !wr_cyc;

  always_comb begin
    state_nx = state;
    phase_nx = phase;
    if (in_bus && ph_last)
      phase_nx = (phase == P_GAP) ? P_SETUP : bus_phase_t'(phase + 2'd1);
    case (state)
      S_IDLE:  if (bus.cmd_valid) state_nx = S_POLL;
      S_POLL:  if ((phase == P_GAP) && ph_last) state_nx = S_CHECK;
      S_CHECK: begin
        if (status_ok)           state_nx = S_XFER;
        else if (poll_exhausted) state_nx = S_RESP;
        else                     state_nx = S_POLL;
      end
      S_XFER:  if ((phase == P_GAP) && ph_last) state_nx = S_RESP;
      S_RESP:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      phase     <= P_SETUP;
      ph_cnt    <= 4'd0;
      poll_cnt  <= 8'd0;
      is_wr     <= 1'b0;
      timed_out <= 1'b0;
    end else begin
      state  <= state_nx;
      phase  <= phase_nx;
      ph_cnt <= (in_bus && !ph_last) ? ph_cnt + 4'd1 : 4'd0;
      if (take_cmd) begin
        is_wr     <= bus.cmd_write;
        poll_cnt  <= 8'd0;
        timed_out <= 1'b0;
      end else if ((state == S_CHECK) && !status_ok) begin
        poll_cnt  <= poll_cnt + 8'd1;
        timed_out <= poll_exhausted;
      end
    end
  end

  // Data path registers carry no reset. The outputs are gated by the control state instead.
  always_ff @(posedge clk) begin
    if (take_cmd)   wr_byte_p0 <= bus.cmd_wdata;
    if (sample_din) rd_byte_p1 <= bus.bus_din;
  end

  always_comb begin
    bus.cmd_ready   = (state == S_IDLE) && !rst;
    bus.rsp_valid   = (state == S_RESP);
    bus.rsp_timeout = (state == S_RESP) && timed_out;
    bus.rsp_data    = ((state == S_RESP) && !timed_out && !is_wr) ? rd_byte_p1 : 8'h00;
    bus.bus_addr    = (state == S_XFER) ? 2'd1 : 2'd0;
    bus.bus_ncs     = !(in_bus && (phase == P_ACTIVE));
    bus.bus_nwe     = !(wr_cyc && (phase == P_ACTIVE));
    bus.bus_doe     = wr_cyc && (phase != P_GAP);
    bus.bus_dout    = (wr_cyc && (phase != P_GAP)) ? wr_byte_p0 : 8'h00;
    bus.bus_nrst    = !rst;
  end

endmodule

// File: doc/uart_bus_master.md
# uart_bus_master

Bus initiator for the UART peripheral's 8-bit microprocessor-style register interface (addr/ncs/nwe/nrst, tri-state data). Turns single-byte transmit/receive commands into status-poll and data-register bus cycles, then returns one response per command. Used as an on-FPGA host for the UART peripheral, and as the driver side in its benches. The top level owns the data-bus tri-state buffer.

## Interface

Parameters:
- ACTIVE_CYCLES, 4: clocks ncs is held low per bus cycle; legal range 4–15.
- IDLE_CYCLES, 2: gap clocks after each bus cycle; legal range 1–15.
- POLL_MAX, 255: maximum status reads per command; 0 = unlimited; legal range 0–255.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted when high together with cmd_valid
- cmd_write  in  1  1 = transmit cmd_wdata; 0 = receive one byte
- cmd_wdata  in  8  byte to transmit
- rsp_valid  out  1  one-cycle pulse, one per accepted command
- rsp_data  out  8  received byte; 0 for writes and timeouts
- rsp_timeout  out  1  qualifies rsp_valid: poll limit exhausted
- bus_addr  out  2  register address
- bus_ncs  out  1  chip select, active low
- bus_nwe  out  1  write enable, active low
- bus_nrst  out  1  peripheral reset, active low; equals ~rst
- bus_dout  out  8  data driven onto the bus
- bus_doe  out  1  output enable for bus_dout
- bus_din  in  8  bus data sampled during reads

## Operation

- Registers: addr 0 = status, with bit0 = tx_busy and bit1 = rx_available. Addr 1 = data: read returns the RX byte, write loads the TX byte.
- Command FSM states: IDLE, POLL, CHECK, XFER, RESP.
  - IDLE: cmd_ready = 1. On handshake, latch cmd_write and cmd_wdata, clear the poll counter, go to POLL.
  - POLL: one read bus cycle at addr 0, then CHECK.
  - CHECK (1 clk): the condition is status[0]==0 for a write, or status[1]==1 for a read.
    - Condition met: go to XFER.
    - Otherwise, if POLL_MAX≠0 and the poll counter reaches POLL_MAX: go to RESP with timeout.
    - Otherwise: increment the counter and return to POLL.
  - XFER: one bus cycle at addr 1. Write cycle for a write command, read cycle for a read command. Then RESP.
  - RESP (1 clk): rsp_valid = 1, then IDLE.
- Bus-cycle sub-FSM states: SETUP, ACTIVE, HOLD, GAP.
  - SETUP (1 clk): bus_addr valid, ncs = 1. For a write, bus_dout = data and bus_doe = 1.
  - ACTIVE (ACTIVE_CYCLES clk): ncs = 0; nwe = 0 for a write, otherwise 1. bus_addr and bus_dout stay stable.
  - On a read, bus_din is registered at the edge ending the last ACTIVE clock.
  - HOLD (1 clk): ncs = 1, nwe = 1. Address and write data are held.
  - GAP (IDLE_CYCLES clk): bus_doe = 0, ncs = 1.
- bus_doe is never 1 while nwe = 1 and ncs = 0, so there is no contention with peripheral read data.
- Exactly one status read is required before every transfer, even if the previous status was already good.
- Reset values: cmd_ready = 0 while rst = 1, then 1. rsp_valid = 0, rsp_data = 0, rsp_timeout = 0, bus_addr = 0, bus_ncs = 1, bus_nwe = 1, bus_doe = 0, bus_dout = 0, bus_nrst = 0.
- Reset mid-operation: rst overrides everything on the next edge. Bus outputs return to their reset values, the command is dropped and no response is issued.
- cmd_valid while busy is ignored; cmd_ready = 0 outside IDLE.

## Timing

- Bus cycle length: L = 2 + ACTIVE_CYCLES + IDLE_CYCLES (8 by default).
- Let T be the clock edge at which the cmd_valid/cmd_ready handshake occurs.
  - SETUP of the first poll is the cycle after T.
  - With an immediate status pass, rsp_valid is high in cycle T + 2L + 2 (T+18 with defaults).
  - Each failed poll adds L + 1 cycles.
- rsp_valid lasts exactly 1 cycle. rsp_data and rsp_timeout are valid only in that cycle and reset to 0 afterwards.
- cmd_ready returns high in the cycle after rsp_valid. A back-to-back command can be accepted on that edge.
- ACTIVE_CYCLES ≥ 4 covers the peripheral's two-flop input sync plus its registered read-data and output-enable path.
- Timeout: after POLL_MAX failed polls, rsp_valid is asserted with rsp_timeout = 1 and rsp_data = 0. No XFER cycle is issued.

## Test plan

- Write 0xA5, status model returns 0x00. Required response:
  - one addr-0 read, then one addr-1 cycle with ncs low for 4 clk, nwe low and bus_dout = 0xA5;
  - rsp_valid at T+18 with rsp_data = 0 and rsp_timeout = 0.
- Read, with status returning 0x00 twice and then 0x02, and addr 1 returning 0x3C. Required response: three status cycles, one data read, rsp_data = 0x3C, rsp_valid at T+36.
- POLL_MAX = 3, write command, status stuck at 0x01. Required response: exactly 3 status reads, no write cycle, rsp_timeout = 1, rsp_data = 0.
- Assert rst during ACTIVE of a write cycle. Required response: next cycle ncs = 1, nwe = 1, bus_doe = 0, bus_nrst = 0; no rsp_valid; after release, a fresh command completes normally.
- Back-to-back write 0x01 then read, with cmd_valid held high. Required response:
  - second command accepted the cycle after the first rsp_valid;
  - no overlap of ncs-low windows;
  - bus_doe = 0 whenever ncs = 0 and nwe = 1.
- Loopback with the real UART peripheral, tx tied to rx: write 0x55, then read. Required response: rsp_data = 0x55 with no timeout.
